// File: rtl/geofence_pkg.sv
// geofence_pkg: shared types and width helpers for the geofence point-in-polygon engine.
//   state_t             controller states
//   W_* / NV_*          legal parameter ranges
//   diff/prod/cross     derived signed operand widths for a W-bit coordinate
package geofence_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SORT,
      ST_TEST,
      ST_DONE
   } state_t;

   localparam int unsigned W_MIN  = 4;
   localparam int unsigned W_MAX  = 16;
   localparam int unsigned NV_MIN = 3;
   localparam int unsigned NV_MAX = 8;

   // Width of a coordinate difference, of a product of two differences, and of
   // the final cross product for W-bit unsigned coordinates.
   function automatic int unsigned diff_width(input int unsigned w);
      return w + 1;
   endfunction

   function automatic int unsigned prod_width(input int unsigned w);
      return 2 * w + 2;
   endfunction

   function automatic int unsigned cross_width(input int unsigned w);
      return 2 * w + 3;
   endfunction

   localparam int unsigned DIFF_W_MAX  = W_MAX + 1;
   localparam int unsigned PROD_W_MAX  = 2 * W_MAX + 2;
   localparam int unsigned CROSS_W_MAX = 2 * W_MAX + 3;

endpackage

// File: rtl/geofence_cross.sv
// geofence_cross: combinational 2-D cross product (a-o) x (b-o), full precision.
//   ax, ay, bx, by, ox, oy   W-bit unsigned point coordinates
//   res                      (ax-ox)*(by-oy) - (bx-ox)*(ay-oy), 2W+3-bit signed
module geofence_cross
   import geofence_pkg::*;
#(
   parameter int unsigned W = 10
) (
   input  logic [W-1:0] ax,
   input  logic [W-1:0] ay,
   input  logic [W-1:0] bx,
   input  logic [W-1:0] by,
   input  logic [W-1:0] ox,
   input  logic [W-1:0] oy,
   output logic signed [cross_width(W)-1:0] res
);

   localparam int unsigned DW = diff_width(W);
   localparam int unsigned PW = prod_width(W);
   localparam int unsigned CW = cross_width(W);

   logic signed [DW-1:0] dax, day, dbx, dby;
   logic signed [PW-1:0] p0, p1;

   // Zero-extend to W+1 bits so the differences can never overflow.
   always_comb begin
      dax = $signed({1'b0, ax}) - $signed({1'b0, ox});
      day = $signed({1'b0, ay}) - $signed({1'b0, oy});
      dbx = $signed({1'b0, bx}) - $signed({1'b0, ox});
      dby = $signed({1'b0, by}) - $signed({1'b0, oy});
      p0  = PW'(dax) * PW'(dby);
      p1  = PW'(dbx) * PW'(day);
      res = CW'(p0) - CW'(p1);
   end

endmodule

// File: rtl/geofence_gen.sv
// geofence_gen: decides whether a target point lies inside a convex polygon.
// A job is the target followed by NV vertices in any order. The vertices are
// insertion-sorted counter-clockwise around V0 (one compare per cycle), then
// every edge is tested against the target (one edge per cycle, early exit).
//   clk, reset     clock, asynchronous active-high reset
//   X, Y           point coordinates, captured when in_valid=1 and busy=0
//   in_valid       point strobe
//   busy           job in progress, points ignored
//   valid          one-cycle result strobe
//   is_inside      result, meaningful while valid=1
module geofence_gen
   import geofence_pkg::*;
#(
   parameter int unsigned W              = 10,
   parameter int unsigned NV             = 6,
   parameter bit          ON_EDGE_INSIDE = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   input  logic         in_valid,
   output logic         busy,
   output logic         valid,
   output logic         is_inside
);

   localparam int unsigned IW = $clog2(NV + 1);
   localparam int unsigned AW = $clog2(NV);
   localparam int unsigned CW = cross_width(W);
   localparam logic [IW-1:0] LAST   = IW'(NV);
   localparam logic [IW-1:0] LAST_K = IW'(NV - 1);

   state_t        state, state_nxt;
   logic [IW-1:0] cnt, cnt_nxt;
   logic [IW-1:0] si, si_nxt;
   logic [IW-1:0] sj, sj_nxt;
   logic [IW-1:0] k, k_nxt;
   logic          on_edge, on_edge_nxt;
   logic          busy_nxt, valid_nxt, inside_nxt;
   logic          capture, do_swap;

   logic [W-1:0]  tx, ty;
   logic [W-1:0]  vx [NV];
   logic [W-1:0]  vy [NV];

   logic [AW-1:0] a_j, a_jm1, a_k, a_kn;
   logic signed [CW-1:0] c_sort, c_test;

   // Array addresses for the sort pair (j-1, j) and the test edge (k, k+1 mod NV).
   always_comb begin
      a_j   = AW'(sj);
      a_jm1 = AW'(sj - IW'(1));
      a_k   = AW'(k);
      a_kn  = (k == LAST_K) ? '0 : AW'(k + IW'(1));
   end

   // Sort compare: positive when V[j] belongs before V[j-1] around pivot V0.
   geofence_cross #(.W(W)) u_cross_sort (
      .ax (vx[a_j]),
      .ay (vy[a_j]),
      .bx (vx[a_jm1]),
      .by (vy[a_jm1]),
      .ox (vx[0]),
      .oy (vy[0]),
      .res(c_sort)
   );

   // Edge test against the target.
   geofence_cross #(.W(W)) u_cross_test (
      .ax (vx[a_k]),
      .ay (vy[a_k]),
      .bx (vx[a_kn]),
      .by (vy[a_kn]),
      .ox (tx),
      .oy (ty),
      .res(c_test)
   );

   // Next-state and control.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      si_nxt      = si;
      sj_nxt      = sj;
      k_nxt       = k;
      on_edge_nxt = on_edge;
      inside_nxt  = is_inside;
      capture     = 1'b0;
      do_swap     = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (in_valid) begin
               capture   = 1'b1;
               cnt_nxt   = IW'(1);
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               capture = 1'b1;
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  si_nxt    = IW'(2);
                  sj_nxt    = IW'(2);
                  state_nxt = ST_SORT;
               end else begin
                  cnt_nxt = cnt + IW'(1);
               end
            end
         end
         ST_SORT: begin
            // si: entry being inserted; sj: its current slot while it sinks toward V1.
            do_swap = !c_sort[CW-1] && (c_sort != '0);
            if (do_swap && (sj != IW'(2))) begin
               sj_nxt = sj - IW'(1);
            end else if (si == LAST_K) begin
               si_nxt      = '0;
               sj_nxt      = '0;
               k_nxt       = '0;
               on_edge_nxt = 1'b0;
               state_nxt   = ST_TEST;
            end else begin
               si_nxt = si + IW'(1);
               sj_nxt = si + IW'(1);
            end
         end
         ST_TEST: begin
            if (c_test[CW-1]) begin
               inside_nxt = 1'b0;
               k_nxt      = '0;
               state_nxt  = ST_DONE;
            end else begin
               if (c_test == '0) on_edge_nxt = 1'b1;
               if (k == LAST_K) begin
                  inside_nxt = (on_edge || (c_test == '0)) ? ON_EDGE_INSIDE : 1'b1;
                  k_nxt      = '0;
                  state_nxt  = ST_DONE;
               end else begin
                  k_nxt = k + IW'(1);
               end
            end
         end
         ST_DONE: begin
            on_edge_nxt = 1'b0;
            state_nxt   = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      busy_nxt  = (state_nxt == ST_SORT) || (state_nxt == ST_TEST) || (state_nxt == ST_DONE);
      valid_nxt = (state_nxt == ST_DONE);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         si        <= '0;
         sj        <= '0;
         k         <= '0;
         on_edge   <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         is_inside <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         si        <= si_nxt;
         sj        <= sj_nxt;
         k         <= k_nxt;
         on_edge   <= on_edge_nxt;
         busy      <= busy_nxt;
         valid     <= valid_nxt;
         is_inside <= inside_nxt;
      end
   end

   // Point storage: rewritten by every job, so it carries no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         if (state == ST_IDLE) begin
            tx <= X;
            ty <= Y;
         end else begin
            vx[AW'(cnt - IW'(1))] <= X;
            vy[AW'(cnt - IW'(1))] <= Y;
         end
      end
      if (do_swap) begin
         vx[a_j]   <= vx[a_jm1];
         vy[a_j]   <= vy[a_jm1];
         vx[a_jm1] <= vx[a_j];
         vy[a_jm1] <= vy[a_j];
      end
   end

endmodule

// File: tb/tb_geofence_gen.sv
// tb_geofence_gen: directed bench for geofence_gen.
// Three instances share clk/reset/X/Y: a square engine (NV=4, edge=outside),
// the same with edge=inside, and a hexagon engine (NV=6). sel routes in_valid.
module tb_geofence_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] X, Y;
   logic       in_valid;
   int         sel;

   logic iv0, iv1, iv2;
   logic busy0, valid0, in0;
   logic busy1, valid1, in1;
   logic busy2, valid2, in2;
   logic busy_s, valid_s, in_s;

   int checks = 0;
   int fails  = 0;
   int pulses0 = 0;
   int vx [8];
   int vy [8];

   always #5 clk = ~clk;

   assign iv0 = in_valid && (sel == 0);
   assign iv1 = in_valid && (sel == 1);
   assign iv2 = in_valid && (sel == 2);

   geofence_gen #(.W(10), .NV(4), .ON_EDGE_INSIDE(1'b0)) dut_sq (
      .clk(clk), .reset(reset), .X(X), .Y(Y), .in_valid(iv0),
      .busy(busy0), .valid(valid0), .is_inside(in0)
   );

   geofence_gen #(.W(10), .NV(4), .ON_EDGE_INSIDE(1'b1)) dut_sqe (
      .clk(clk), .reset(reset), .X(X), .Y(Y), .in_valid(iv1),
      .busy(busy1), .valid(valid1), .is_inside(in1)
   );

   geofence_gen #(.W(10), .NV(6), .ON_EDGE_INSIDE(1'b0)) dut_hex (
      .clk(clk), .reset(reset), .X(X), .Y(Y), .in_valid(iv2),
      .busy(busy2), .valid(valid2), .is_inside(in2)
   );

   always_comb begin
      case (sel)
         0:       begin busy_s = busy0; valid_s = valid0; in_s = in0; end
         1:       begin busy_s = busy1; valid_s = valid1; in_s = in1; end
         default: begin busy_s = busy2; valid_s = valid2; in_s = in2; end
      endcase
   end

   always @(posedge clk) begin
      if (valid0) pulses0 <= pulses0 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Optional random gap, then one point captured on the next rising edge.
   task automatic send_point(input int px, input int py, input int maxgap);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      X = 10'(px);
      Y = 10'(py);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_job(input int s, input int tx, input int ty, input int nv, input int maxgap);
      sel = s;
      send_point(tx, ty, maxgap);
      for (int i = 0; i < nv; i++) send_point(vx[i], vy[i], maxgap);
   endtask

   // Called #1 after the last capture; returns latency in cycles and the result.
   task automatic wait_result(input string tag, output int lat, output logic res);
      lat = 0;
      check({tag, "_busy"}, 32'(busy_s), 1);
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (valid_s) break;
      end
      check({tag, "_valid"}, 32'(valid_s), 1);
      res = in_s;
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, 32'({valid_s, busy_s}), 0);
   endtask

   task automatic set_square();
      vx[0] = 300; vy[0] = 300;
      vx[1] = 100; vy[1] = 100;
      vx[2] = 100; vy[2] = 300;
      vx[3] = 300; vy[3] = 100;
   endtask

   task automatic set_hex_reversed();
      vx[0] = 154; vy[0] = 306;
      vx[1] = 154; vy[1] = 718;
      vx[2] = 512; vy[2] = 924;
      vx[3] = 870; vy[3] = 718;
      vx[4] = 870; vy[4] = 306;
      vx[5] = 512; vy[5] = 100;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   lat;
      int   p0;
      logic res;

      reset = 1'b1; in_valid = 1'b0; X = '0; Y = '0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sq",  32'({busy0, valid0, in0}), 0);
      check("rst_sqe", 32'({busy1, valid1, in1}), 0);
      check("rst_hex", 32'({busy2, valid2, in2}), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Square, target at centre: 2 sort compares + 4 edges.
      set_square();
      send_job(0, 200, 200, 4, 0);
      wait_result("sq_in", lat, res);
      check("sq_in_res", 32'(res), 1);
      check("sq_in_lat", lat, 6);

      // Outside to the right: last edge is the negative one.
      send_job(0, 400, 200, 4, 0);
      wait_result("sq_right", lat, res);
      check("sq_right_res", 32'(res), 0);
      check("sq_right_lat", lat, 6);

      // Outside above: first edge negative, early exit.
      send_job(0, 200, 400, 4, 0);
      wait_result("sq_above", lat, res);
      check("sq_above_res", 32'(res), 0);
      check("sq_above_lat", lat, 3);

      // On the bottom edge.
      send_job(0, 200, 100, 4, 0);
      wait_result("edge_out", lat, res);
      check("edge_out_res", 32'(res), 0);
      send_job(1, 200, 100, 4, 0);
      wait_result("edge_in", lat, res);
      check("edge_in_res", 32'(res), 1);

      // Hexagon fed in clockwise order.
      set_hex_reversed();
      send_job(2, 512, 512, 6, 0);
      wait_result("hex_in", lat, res);
      check("hex_in_res", 32'(res), 1);
      check("hex_in_lat_ok", 32'(lat <= 24), 1);
      send_job(2, 0, 1023, 6, 0);
      wait_result("hex_out", lat, res);
      check("hex_out_res", 32'(res), 0);

      // Reset after 3 captures, then a gapped job.
      set_square();
      sel = 0;
      send_point(999, 999, 0);
      send_point(vx[0], vy[0], 0);
      send_point(vx[1], vy[1], 0);
      p0 = pulses0;
      #2 reset = 1'b1;
      #1 check("rst_load_busy", 32'({busy0, valid0}), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      send_job(0, 200, 200, 4, 3);
      wait_result("gap_job", lat, res);
      check("gap_job_res", 32'(res), 1);
      check("gap_job_pulses", pulses0 - p0, 1);

      // Reset while sorting: asynchronous clear and no result afterwards.
      send_job(0, 200, 200, 4, 0);
      p0 = pulses0;
      #2 reset = 1'b1;
      #1 check("rst_sort_busy", 32'({busy0, valid0, in0}), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_sort_no_pulse", pulses0 - p0, 0);

      // Garbage while busy, then the next job starts right after DONE.
      send_job(0, 200, 200, 4, 0);
      X = 10'd0; Y = 10'd0; in_valid = 1'b1;
      wait_result("b2b_a", lat, res);
      check("b2b_a_res", 32'(res), 1);
      send_job(0, 400, 200, 4, 0);
      wait_result("b2b_b", lat, res);
      check("b2b_b_res", 32'(res), 0);
      check("b2b_b_lat", lat, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/geofence_gen.md
GEOFENCE_GEN -- requirements
Module: geofence_gen

Interface
REQ-001 Parameter W, default 10: unsigned coordinate width; legal range 4..16.
REQ-002 Parameter NV, default 6: polygon vertex count; legal range 3..8.
REQ-003 Parameter ON_EDGE_INSIDE, default 0: when 1, a target exactly on an edge SHALL report inside.
REQ-004 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 X  input  W  unsigned point X coordinate.
REQ-007 Y  input  W  unsigned point Y coordinate.
REQ-008 in_valid  input  1  X/Y valid this cycle.
REQ-009 busy  output  1  high while a job is being computed; input points are ignored.
REQ-010 valid  output  1  one-cycle pulse marking a result.
REQ-011 is_inside  output  1  result; meaningful only while valid=1.

Function
REQ-012 A job SHALL be NV+1 points: the target T first, then vertices V0..V(NV-1) of a convex polygon in arbitrary order.
REQ-013 A point SHALL be captured on each cycle with in_valid=1 and busy=0; in_valid gaps of any length SHALL be allowed.
REQ-014 States: IDLE -> LOAD on the first capture; LOAD -> SORT on the capture of the last vertex; SORT -> TEST when sorting completes; TEST -> DONE on a decision; DONE -> IDLE after one cycle.
REQ-015 busy SHALL be 1 from the cycle after the last capture through the DONE cycle, and 0 otherwise.
REQ-016 cross(a,b,o) SHALL be (ax-ox)*(by-oy) - (bx-ox)*(ay-oy).
REQ-017 Operand differences SHALL be W+1-bit signed, products 2W+2-bit signed, and the result 2W+3-bit signed; no truncation is allowed.
REQ-018 SORT SHALL hold V0 fixed as pivot and insertion-sort V1..V(NV-1) into counter-clockwise order.
REQ-019 The SORT order rule: Vi precedes Vj when cross(Vi,Vj,V0) > 0.
REQ-020 SORT SHALL perform exactly one compare per cycle, swapping adjacent entries in place.
REQ-021 SORT SHALL take at most (NV-1)(NV-2)/2 + NV cycles.
REQ-022 TEST SHALL evaluate one edge per cycle: c_k = cross(Vk, V((k+1) mod NV), T), for k = 0..NV-1.
REQ-023 Any c_k < 0 SHALL end TEST immediately with is_inside=0 (early exit).
REQ-024 A c_k = 0 SHALL set is_inside=ON_EDGE_INSIDE unless another edge yields c_k < 0.
REQ-025 If every c_k > 0, the result SHALL be is_inside=1.
REQ-026 valid SHALL pulse high for exactly the DONE cycle; is_inside SHALL be held stable during that cycle.
REQ-027 Worst-case latency from last capture to valid SHALL be at most (NV-1)(NV-2)/2 + 2NV + 2 cycles.
REQ-028 Degenerate (collinear) vertex sets SHALL still terminate within the REQ-027 bound; the is_inside value is unspecified.
REQ-029 A new job SHALL be acceptable on the cycle after DONE; no points SHALL be lost across back-to-back jobs.

Reset
REQ-030 reset SHALL asynchronously force: state=IDLE, busy=0, valid=0, is_inside=0, all counters and indices to 0.
REQ-031 Reset asserted mid-LOAD, SORT or TEST SHALL discard the job; no valid pulse SHALL follow.
REQ-032 Point storage needs no reset; it SHALL be rewritten by every job.

Structure
REQ-033 Package geofence_pkg SHALL hold the state enum, the W/NV legal-range constants, and derived width localparams (difference, product, cross).
REQ-034 Sub-module geofence_cross SHALL be purely combinational, parametrised by W, and compute REQ-016 to REQ-017.
REQ-035 The top SHALL instantiate geofence_cross twice, one each for SORT and TEST, or once with operand muxing; either is acceptable.

Verification
REQ-036 NV=4: T=(200,200); vertices (300,300),(100,100),(100,300),(300,100) -> valid pulse once, is_inside=1, within 14 cycles.
REQ-037 Same square, T=(400,200) -> is_inside=0; TEST exits on the first negative edge.
REQ-038 Same square, T=(200,100): ON_EDGE_INSIDE=0 -> is_inside=0; ON_EDGE_INSIDE=1 -> is_inside=1.
REQ-039 NV=6, W=10: hexagon (512,100),(870,306),(870,718),(512,924),(154,718),(154,306) fed reversed, T=(512,512) -> is_inside=1; with T=(0,1023) -> is_inside=0.
REQ-040 Reset asserted after 3 captures, then a full job with random in_valid gaps -> exactly one valid pulse, with the correct result.
REQ-041 Extra in_valid points driven while busy=1 -> ignored; result unchanged; next job captured immediately after DONE.
